// File: rtl/multicycle_controller.sv
// Multi-cycle RV64 sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared, variable-latency memory port.
// Define MC_PERF_CNT_EN to add the cycle_count / instret_count performance counter outputs.
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        retire,
    output logic        trap,
    output logic [2:0]  state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [63:0] cycle_count,
    output logic [63:0] instret_count
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // The request that would make the counter reach TIMEOUT_CYCLES is the last one allowed.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0] cur_state;
    logic [2:0] next_state;
    logic [7:0] wait_cnt;
    logic       legal;
    logic       timeout;

    always_comb begin
        legal   = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
                  (opcode == OP_ST) || (opcode == OP_BR);
        timeout = !mem_ready && (wait_cnt == WAIT_LAST);
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        next_state = cur_state;
        if (reset) begin
            case (cur_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = S_DECODE;
                    end else if (timeout) begin
                        next_state = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_b  = 2'b10;
                    next_state = legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    case (opcode)
                        OP_R: begin
                            alu_op     = 2'b10;
                            next_state = S_WB;
                        end
                        OP_I: begin
                            alu_src_b  = 2'b10;
                            alu_op     = 2'b10;
                            next_state = S_WB;
                        end
                        OP_LD, OP_ST: begin
                            alu_src_b  = 2'b10;
                            next_state = S_MEM;
                        end
                        OP_BR: begin
                            alu_op     = 2'b01;
                            pc_write   = zero;
                            pc_src     = zero;
                            retire     = 1'b1;
                            next_state = S_FETCH;
                        end
                        default: next_state = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (opcode == OP_ST);
                    if (mem_ready) begin
                        if (opcode == OP_ST) begin
                            retire     = 1'b1;
                            next_state = S_FETCH;
                        end else begin
                            next_state = S_WB;
                        end
                    end else if (timeout) begin
                        next_state = S_TRAP;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode == OP_LD);
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                S_TRAP: trap = 1'b1;
                default: next_state = S_TRAP;
            endcase
        end
    end

    always_comb state = reset ? cur_state : 3'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= S_FETCH;
            wait_cnt  <= '0;
        end else begin
            cur_state <= next_state;
            if (mem_ready || (next_state != cur_state))
                wait_cnt <= '0;
            else if ((cur_state == S_FETCH) || (cur_state == S_MEM))
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (cur_state != S_TRAP)
                cycle_count <= cycle_count + 64'd1;
            if (retire)
                instret_count <= instret_count + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level reference model expanded to per-cycle expectations.
// Build with MC_PERF_CNT_EN defined to also check the performance counters.
module tb_multicycle_controller;

    localparam int unsigned TO = 16;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        reg_write, mem_to_reg, retire, trap;
    logic [2:0]  state;
`ifdef MC_PERF_CNT_EN
    logic [63:0] cycle_count, instret_count;
`endif

    multicycle_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .retire(retire), .trap(trap), .state(state)
`ifdef MC_PERF_CNT_EN
        , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        zr;
        logic [6:0]  opc;
        logic [17:0] exp;
    } ent_t;

    ent_t  q[$];
    string tags[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_retired = 0;
    int    dut_retired = 0;
    logic  trapped;
    logic [63:0] m_cyc, m_ret;
    logic  perf_valid = 1'b0;

    // Field order: state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, retire, trap
    function automatic logic [17:0] ev(input logic [2:0] s, input logic req, we, io, irw, pcw, pcs, a,
                                       input logic [1:0] b, op, input logic rw, m2r, ret, trp);
        return {s, req, we, io, irw, pcw, pcs, a, b, op, rw, m2r, ret, trp};
    endfunction

    function automatic void push(input logic rst, rdy, zr, input logic [6:0] opc,
                                 input logic [17:0] e, input string t);
        ent_t x;
        x.rst = rst; x.rdy = rdy; x.zr = zr; x.opc = opc; x.exp = e;
        q.push_back(x);
        tags.push_back(t);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Expands one instruction into expected cycles; sets trapped when it ends in TRAP.
    task automatic add_instr(input logic [6:0] opc, input int fw, input int mw, input logic zr);
        logic ld, st;
        ld = (opc == OP_LD);
        st = (opc == OP_ST);
        trapped = 1'b0;
        for (int i = 0; i < fw && i < int'(TO); i++)
            push(1, 0, rb(), opc, ev(0, 1,0,0,0,0,0, 0,2'b01,2'b00, 0,0,0,0), "fetch_wait");
        if (fw >= int'(TO)) begin trapped = 1'b1; return; end
        push(1, 1, rb(), opc, ev(0, 1,0,0,1,1,0, 0,2'b01,2'b00, 0,0,0,0), "fetch_done");
        push(1, rb(), rb(), opc, ev(1, 0,0,0,0,0,0, 0,2'b10,2'b00, 0,0,0,0), "decode");
        case (opc)
            OP_R: begin
                push(1, rb(), rb(), opc, ev(2, 0,0,0,0,0,0, 1,2'b00,2'b10, 0,0,0,0), "exec_r");
                push(1, rb(), rb(), opc, ev(4, 0,0,0,0,0,0, 0,2'b00,2'b00, 1,0,1,0), "wb_r");
                exp_retired++;
            end
            OP_I: begin
                push(1, rb(), rb(), opc, ev(2, 0,0,0,0,0,0, 1,2'b10,2'b10, 0,0,0,0), "exec_i");
                push(1, rb(), rb(), opc, ev(4, 0,0,0,0,0,0, 0,2'b00,2'b00, 1,0,1,0), "wb_i");
                exp_retired++;
            end
            OP_BR: begin
                push(1, rb(), zr, opc, ev(2, 0,0,0,0,zr,zr, 1,2'b00,2'b01, 0,0,1,0), "exec_br");
                exp_retired++;
            end
            OP_LD, OP_ST: begin
                push(1, rb(), rb(), opc, ev(2, 0,0,0,0,0,0, 1,2'b10,2'b00, 0,0,0,0), "exec_ls");
                for (int i = 0; i < mw && i < int'(TO); i++)
                    push(1, 0, rb(), opc, ev(3, 1,st,1,0,0,0, 0,2'b00,2'b00, 0,0,0,0), "mem_wait");
                if (mw >= int'(TO)) begin trapped = 1'b1; return; end
                push(1, 1, rb(), opc, ev(3, 1,st,1,0,0,0, 0,2'b00,2'b00, 0,0,st,0), "mem_done");
                if (ld)
                    push(1, rb(), rb(), opc, ev(4, 0,0,0,0,0,0, 0,2'b00,2'b00, 1,1,1,0), "wb_ld");
                exp_retired++;
            end
            default: trapped = 1'b1;
        endcase
    endtask

    task automatic trap_then_reset(input int n);
        for (int i = 0; i < n; i++)
            push(1, rb(), rb(), OP_BAD, ev(7, 0,0,0,0,0,0, 0,2'b00,2'b00, 0,0,0,1), "trap_hold");
        push(0, rb(), rb(), OP_R, 18'd0, "reset_out");
    endtask

    task automatic run_q();
        ent_t e;
        string t;
        logic [17:0] obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            t = tags.pop_front();
            @(posedge clk);
            #1;
            reset = e.rst; mem_ready = e.rdy; zero = e.zr; opcode = e.opc;
            @(negedge clk);
            obs = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, mem_to_reg, retire, trap};
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s t=%0t got=%05h exp=%05h", t, $time, obs, e.exp);
            end
            if (retire === 1'b1) dut_retired++;
`ifdef MC_PERF_CNT_EN
            if (perf_valid) begin
                checks++;
                assert (cycle_count === m_cyc) else begin
                    errors++;
                    $error("FAIL cycle_count t=%0t got=%0d exp=%0d", $time, cycle_count, m_cyc);
                end
                checks++;
                assert (instret_count === m_ret) else begin
                    errors++;
                    $error("FAIL instret_count t=%0t got=%0d exp=%0d", $time, instret_count, m_ret);
                end
            end
            if (!e.rst) begin
                m_cyc = '0; m_ret = '0; perf_valid = 1'b1;
            end else begin
                if (e.exp[17:15] != 3'd7) m_cyc = m_cyc + 64'd1;
                if (e.exp[1]) m_ret = m_ret + 64'd1;
            end
`endif
        end
    endtask

    initial begin
        logic [6:0] legal_ops [5];
        legal_ops[0] = OP_R; legal_ops[1] = OP_I; legal_ops[2] = OP_LD;
        legal_ops[3] = OP_ST; legal_ops[4] = OP_BR;

        push(0, 1, 0, OP_R, 18'd0, "reset0");
        push(0, 0, 1, OP_ST, 18'd0, "reset1");
        add_instr(OP_R, 0, 0, 0);
        add_instr(OP_LD, 0, 3, 0);
        add_instr(OP_BR, 0, 0, 1);
        add_instr(OP_BR, 0, 0, 0);
        add_instr(OP_ST, 2, 1, 0);
        add_instr(OP_I, 1, 0, 1);
        run_q();

        add_instr(OP_BAD, 0, 0, 0);
        trap_then_reset(10);
        add_instr(OP_R, 0, 0, 0);
        run_q();

        add_instr(OP_R, TO, 0, 0);
        trap_then_reset(3);
        add_instr(OP_LD, 0, TO, 0);
        trap_then_reset(2);
        run_q();

        // Store aborted by reset while its MEM request is outstanding.
        push(1, 1, 0, OP_ST, ev(0, 1,0,0,1,1,0, 0,2'b01,2'b00, 0,0,0,0), "fetch_done");
        push(1, 0, 0, OP_ST, ev(1, 0,0,0,0,0,0, 0,2'b10,2'b00, 0,0,0,0), "decode");
        push(1, 0, 0, OP_ST, ev(2, 0,0,0,0,0,0, 1,2'b10,2'b00, 0,0,0,0), "exec_ls");
        push(1, 0, 0, OP_ST, ev(3, 1,1,1,0,0,0, 0,2'b00,2'b00, 0,0,0,0), "mem_wait");
        push(0, 1, 0, OP_ST, 18'd0, "mem_reset");
        push(1, 0, 0, OP_ST, ev(0, 1,0,0,0,0,0, 0,2'b01,2'b00, 0,0,0,0), "post_reset_fetch");
        push(1, 1, 0, OP_ST, ev(0, 1,0,0,1,1,0, 0,2'b01,2'b00, 0,0,0,0), "fetch_done");
        push(1, 0, 0, OP_ST, ev(1, 0,0,0,0,0,0, 0,2'b10,2'b00, 0,0,0,0), "decode");
        push(1, 0, 0, OP_ST, ev(2, 0,0,0,0,0,0, 1,2'b10,2'b00, 0,0,0,0), "exec_ls");
        push(1, 1, 0, OP_ST, ev(3, 1,1,1,0,0,0, 0,2'b00,2'b00, 0,0,1,0), "mem_done");
        exp_retired++;
        run_q();

        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            int fw, mw;
            op = legal_ops[$urandom_range(0, 4)];
            fw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            add_instr(op, fw, mw, rb());
        end
        run_q();

        checks++;
        assert (dut_retired == exp_retired) else begin
            errors++;
            $error("FAIL retire_total got=%0d exp=%0d", dut_retired, exp_retired);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM that turns the existing single-cycle datapath blocks (program counter, register file, ALU, ALU control, immediate generator, unified memory) into a multi-cycle RV64 core with one shared memory port. Each instruction is walked through FETCH, DECODE, EXEC, MEM and WB states, and the controller drives every datapath enable and mux select. It also runs a handshake with a variable-latency memory and traps on illegal opcodes or memory timeouts.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum number of cycles a memory request may wait for `mem_ready` before the controller traps. Legal range is 1..255.
- `clk` input, 1: the single clock; all state changes on the rising edge.
- `reset` input, 1: synchronous, active-low reset on the one clock. It is sampled on the rising edge of `clk`.
- `opcode` input, 7: equal to `instruction[6:0]` from the instruction register.
- `zero` input, 1: ALU zero flag.
- `mem_ready` input, 1: memory completion. When asserted, read data is valid or the write has been accepted in that cycle.
- `mem_req` output, 1: memory request, held stable until `mem_ready`.
- `mem_we` output, 1: write strobe, qualified by `mem_req`.
- `iord` output, 1: memory address select. 0 selects PC; 1 selects ALUOut.
- `ir_write` output, 1: load the instruction register.
- `pc_write` output, 1: load the PC.
- `pc_src` output, 1: PC source select. 0 selects ALU result (PC+4); 1 selects the branch target in ALUOut.
- `alu_src_a` output, 1: ALU A select. 0 selects PC; 1 selects rs1.
- `alu_src_b` output, 2: ALU B select. 00 selects rs2, 01 selects constant 4, 10 selects the immediate.
- `alu_op` output, 2: ALUOp. 00 is add, 01 is subtract, 10 is funct-decoded.
- `reg_write` output, 1: register file write enable.
- `mem_to_reg` output, 1: writeback select. 1 selects memory data.
- `retire` output, 1: one-cycle pulse when an instruction completes.
- `trap` output, 1: sticky error flag.
- `state` output, 3: current state, for debug.

## Operation
- State encodings:
  - FETCH is 0, DECODE is 1, EXEC is 2, MEM is 3, WB is 4 and TRAP is 7.
  - Encodings 5 and 6 go to TRAP.
- Supported opcodes:
  - R-type 0110011, I-ALU 0010011, load 0000011, store 0100011 and branch 1100011.
  - Any other opcode goes from DECODE to TRAP.
- Output defaults: every output not listed for a state is 0.
- FETCH:
  - Drive `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01 and `alu_op`=00.
  - On `mem_ready`, assert `ir_write`=1 and `pc_write`=1 (PC+4, `pc_src`=0), then go to DECODE.
- DECODE:
  - Drive `alu_src_a`=0, `alu_src_b`=10 and `alu_op`=00, so the branch target is latched into ALUOut.
  - Legal opcode goes to EXEC; illegal opcode goes to TRAP.
- EXEC by opcode:
  - R-type: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, then go to WB.
  - I-ALU: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=10, then go to WB.
  - Load/store: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00, then go to MEM.
  - Branch: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01. If `zero` is set, assert `pc_write`=1 with `pc_src`=1. Then pulse `retire` and go to FETCH.
- MEM:
  - Drive `mem_req`=1, `iord`=1, and `mem_we`=1 for a store only.
  - On `mem_ready`: a load goes to WB; a store pulses `retire` and goes to FETCH.
- WB:
  - Drive `reg_write`=1, with `mem_to_reg`=1 for a load only.
  - Pulse `retire` and go to FETCH.
- TRAP: `trap`=1 and all other outputs 0. TRAP is only left by reset.
- Wait counter:
  - 8-bit; it increments every FETCH or MEM cycle in which `mem_ready` is 0.
  - It clears on `mem_ready` and on any state change.
  - When it reaches `TIMEOUT_CYCLES` with `mem_ready` still 0, go to TRAP next cycle and drop `mem_req`.
- `opcode` is sampled from DECODE onward only. The instruction register is stable after FETCH, so the opcode is held for the whole instruction.

## Timing
- Reset behaviour:
  - While `reset`=0 at a rising edge, the next state is FETCH, the wait counter is 0 and `trap` is 0.
  - All outputs are gated to 0 while `reset` is low, including `mem_req`.
  - `state` reads 0.
- The first `mem_req` is asserted in the first cycle with `reset`=1.
- Reset asserted mid-instruction aborts it: there is no `retire` and no partial write. Reset overrides the TRAP state.
- Outputs are combinational from `state`, `opcode`, `zero` and `mem_ready`. Write enables are qualified by `mem_ready` in FETCH and MEM.
- Cycles per instruction with zero-wait memory (`mem_ready` high in the same cycle):
  - R-type, I-ALU and store: 4.
  - Load: 5.
  - Branch: 3.
- Each memory wait cycle adds 1. `retire` rises in the final cycle of the instruction.
- `mem_ready` while `mem_req`=0 is ignored.

## Configuration
- `MC_PERF_CNT_EN` defined:
  - Adds output `cycle_count` (64-bit), which increments on every cycle with `reset`=1 and not in TRAP.
  - Adds output `instret_count` (64-bit), which increments on `retire`.
  - Both counters reset to 0 and wrap silently.
- `MC_PERF_CNT_EN` undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Test plan
- Reset then zero-wait R-type (0110011):
  - States 0,1,2,4.
  - `reg_write`=1 only in cycle 4.
  - `retire` in cycle 4.
  - The next FETCH follows.
- Load with 3 wait cycles in MEM:
  - `mem_req`=1 and `iord`=1 is held for 4 cycles.
  - WB has `mem_to_reg`=1.
  - Total is 8 cycles.
- Branch 1100011:
  - With `zero`=1, `pc_write`=1 and `pc_src`=1 in EXEC.
  - With `zero`=0, `pc_write`=0 in EXEC.
  - Both cases take 3 cycles.
- Illegal opcode 1111111:
  - DECODE goes to TRAP and `trap`=1 is held.
  - It persists 10 cycles until `reset`=0, then FETCH.
- `mem_ready` stuck low with `TIMEOUT_CYCLES`=16: TRAP is entered after 16 FETCH wait cycles and `mem_req` drops.
- Reset held low in MEM of a store:
  - `mem_we` drops in the same cycle.
  - State is 0 after the edge.
  - No `retire`.
  - With `MC_PERF_CNT_EN` defined, the counters clear.
